// File: rtl/renkon_loader_pkg.sv
//============================================================================
// Module   : renkon_loader_pkg
// Brief    : Shared widths and loader FSM state type for the renkon feeder.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package renkon_loader_pkg;

    localparam int c_dwidth  = 16;
    localparam int c_imgsize = 12;
    localparam int c_netsize = 11;
    localparam int c_core    = 8;
    localparam int c_corelog = 3;
    localparam int c_lwidth  = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_IMG = 3'd1,
        ST_LOAD_NET = 3'd2,
        ST_REQ      = 3'd3,
        ST_WAIT     = 3'd4,
        ST_DONE     = 3'd5
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/renkon_loader_cnt.sv
//============================================================================
// Module   : loader_cnt
// Brief    : Loadable up-counter; wraps to zero after reaching i_last.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module loader_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_last,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + WIDTH'(1);
        end
    end

    assign o_tc    = (r_count == i_last);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/renkon_loader.sv
//============================================================================
// Module   : renkon_loader
// Brief    : Streams image and per-core weight words into renkon memories,
//            then runs the req/ack handshake. LOADER_CHECKSUM_EN adds a
//            running sum of accepted stream words on output checksum.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module renkon_loader
    import renkon_loader_pkg::*;
#(
    parameter int DWIDTH  = c_dwidth,
    parameter int IMGSIZE = c_imgsize,
    parameter int NETSIZE = c_netsize,
    parameter int CORE    = c_core,
    parameter int CORELOG = c_corelog,
    parameter int LWIDTH  = c_lwidth
) (
    input  logic                      clk,
    input  logic                      xrst,
    input  logic                      start,
    input  logic [IMGSIZE-1:0]        img_words,
    input  logic [NETSIZE-1:0]        net_words,
    input  logic [IMGSIZE-1:0]        in_base,
    input  logic [IMGSIZE-1:0]        out_base,
    input  logic [LWIDTH-1:0]         cfg_total_out,
    input  logic [LWIDTH-1:0]         cfg_total_in,
    input  logic [LWIDTH-1:0]         cfg_img_size,
    input  logic [LWIDTH-1:0]         cfg_fil_size,
    input  logic [LWIDTH-1:0]         cfg_pool_size,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic signed [DWIDTH-1:0]  s_data,
    output logic                      img_we,
    output logic [IMGSIZE-1:0]        input_addr,
    output logic signed [DWIDTH-1:0]  write_img,
    output logic [IMGSIZE-1:0]        output_addr,
    output logic [CORELOG:0]          net_we,
    output logic [NETSIZE-1:0]        net_addr,
    output logic signed [DWIDTH-1:0]  write_net,
    output logic [LWIDTH-1:0]         total_out,
    output logic [LWIDTH-1:0]         total_in,
    output logic [LWIDTH-1:0]         img_size,
    output logic [LWIDTH-1:0]         fil_size,
    output logic [LWIDTH-1:0]         pool_size,
    output logic                      req,
    input  logic                      ack,
`ifdef LOADER_CHECKSUM_EN
    output logic signed [DWIDTH-1:0]  checksum,
`endif
    output logic                      busy,
    output logic                      done
);

    loader_state_t r_state, w_state_nxt;

    logic [IMGSIZE-1:0]       r_img_words, r_in_base, r_out_base;
    logic [NETSIZE-1:0]       r_net_words;
    logic [LWIDTH-1:0]        r_total_out, r_total_in, r_img_size, r_fil_size, r_pool_size;
    logic                     r_img_we, r_req;
    logic [IMGSIZE-1:0]       r_input_addr, r_output_addr;
    logic [DWIDTH-1:0]        r_write_img, r_write_net;
    logic [CORELOG:0]         r_net_we;
    logic [NETSIZE-1:0]       r_net_addr;

    logic                     w_start_acc, w_acc, w_img_acc, w_net_acc, w_in_handshake;
    logic [IMGSIZE-1:0]       w_img_idx;
    logic [NETSIZE-1:0]       w_net_idx;
    logic [CORELOG-1:0]       w_core_idx;
    logic                     w_img_tc, w_net_tc, w_core_tc;

    assign w_start_acc = start && (r_state == ST_IDLE);
    assign w_acc       = s_valid && s_ready;
    assign w_img_acc   = w_acc && (r_state == ST_LOAD_IMG);
    assign w_net_acc   = w_acc && (r_state == ST_LOAD_NET);

    loader_cnt #(.WIDTH(IMGSIZE)) u_img_cnt (
        .clk(clk), .xrst(xrst), .i_load(w_start_acc), .i_load_val('0),
        .i_en(w_img_acc), .i_last(r_img_words - IMGSIZE'(1)),
        .o_count(w_img_idx), .o_tc(w_img_tc)
    );

    loader_cnt #(.WIDTH(NETSIZE)) u_net_cnt (
        .clk(clk), .xrst(xrst), .i_load(w_start_acc), .i_load_val('0),
        .i_en(w_net_acc), .i_last(r_net_words - NETSIZE'(1)),
        .o_count(w_net_idx), .o_tc(w_net_tc)
    );

    loader_cnt #(.WIDTH(CORELOG)) u_core_cnt (
        .clk(clk), .xrst(xrst), .i_load(w_start_acc), .i_load_val('0),
        .i_en(w_net_acc && w_net_tc), .i_last(CORELOG'(CORE - 1)),
        .o_count(w_core_idx), .o_tc(w_core_tc)
    );

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (img_words != '0)      w_state_nxt = ST_LOAD_IMG;
                    else if (net_words != '0) w_state_nxt = ST_LOAD_NET;
                    else                      w_state_nxt = ST_REQ;
                end
            end
            ST_LOAD_IMG: begin
                if (w_acc && w_img_tc)
                    w_state_nxt = (r_net_words != '0) ? ST_LOAD_NET : ST_REQ;
            end
            ST_LOAD_NET: begin
                if (w_acc && w_net_tc && w_core_tc) w_state_nxt = ST_REQ;
            end
            ST_REQ:  w_state_nxt = ST_WAIT;
            ST_WAIT: if (ack) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_img_words <= '0;
            r_net_words <= '0;
            r_in_base   <= '0;
            r_out_base  <= '0;
            r_total_out <= '0;
            r_total_in  <= '0;
            r_img_size  <= '0;
            r_fil_size  <= '0;
            r_pool_size <= '0;
        end else if (w_start_acc) begin
            r_img_words <= img_words;
            r_net_words <= net_words;
            r_in_base   <= in_base;
            r_out_base  <= out_base;
            r_total_out <= cfg_total_out;
            r_total_in  <= cfg_total_in;
            r_img_size  <= cfg_img_size;
            r_fil_size  <= cfg_fil_size;
            r_pool_size <= cfg_pool_size;
        end
    end

    assign w_in_handshake = (w_state_nxt == ST_REQ) || (w_state_nxt == ST_WAIT) ||
                            (w_state_nxt == ST_DONE);

    // A final image write owns input_addr for its strobe cycle; the base
    // address is restored from the following cycle on.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_img_we      <= 1'b0;
            r_input_addr  <= '0;
            r_write_img   <= '0;
            r_output_addr <= '0;
            r_net_we      <= '0;
            r_net_addr    <= '0;
            r_write_net   <= '0;
            r_req         <= 1'b0;
        end else begin
            r_img_we <= w_img_acc;
            r_net_we <= w_net_acc ? ({1'b0, w_core_idx} + (CORELOG+1)'(1)) : '0;
            r_req    <= (r_state == ST_REQ);
            if (w_img_acc) begin
                r_input_addr <= r_in_base + w_img_idx;
                r_write_img  <= s_data;
            end else if (w_in_handshake) begin
                r_input_addr <= r_in_base;
            end
            if (w_in_handshake) r_output_addr <= r_out_base;
            if (w_net_acc) begin
                r_net_addr  <= w_net_idx;
                r_write_net <= s_data;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DWIDTH-1:0] r_checksum;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_acc) begin
            r_checksum <= r_checksum + s_data;
        end
    end

    assign checksum = r_checksum;
`endif

    assign s_ready     = (r_state == ST_LOAD_IMG) || (r_state == ST_LOAD_NET);
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign req         = r_req;
    assign img_we      = r_img_we;
    assign input_addr  = r_input_addr;
    assign write_img   = r_write_img;
    assign output_addr = r_output_addr;
    assign net_we      = r_net_we;
    assign net_addr    = r_net_addr;
    assign write_net   = r_write_net;
    assign total_out   = r_total_out;
    assign total_in    = r_total_in;
    assign img_size    = r_img_size;
    assign fil_size    = r_fil_size;
    assign pool_size   = r_pool_size;

endmodule

`default_nettype wire

// File: tb/tb_renkon_loader.sv
//============================================================================
// Module   : tb_renkon_loader
// Brief    : Self-checking bench for renkon_loader against a write-list model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_renkon_loader;

    localparam int DW = 16;
    localparam int IS = 12;
    localparam int NS = 11;
    localparam int NC = 8;
    localparam int CL = 3;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          xrst = 1'b0;
    logic          start = 1'b0;
    logic [IS-1:0] img_words = '0, in_base = '0, out_base = '0;
    logic [NS-1:0] net_words = '0;
    logic [LW-1:0] cfg_total_out = '0, cfg_total_in = '0, cfg_img_size = '0;
    logic [LW-1:0] cfg_fil_size = '0, cfg_pool_size = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          ack = 1'b0;

    logic          s_ready, img_we, req, busy, done;
    logic [IS-1:0] input_addr, output_addr;
    logic [DW-1:0] write_img, write_net;
    logic [CL:0]   net_we;
    logic [NS-1:0] net_addr;
    logic [LW-1:0] total_out, total_in, img_size, fil_size, pool_size;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    renkon_loader dut (
        .clk(clk), .xrst(xrst), .start(start),
        .img_words(img_words), .net_words(net_words),
        .in_base(in_base), .out_base(out_base),
        .cfg_total_out(cfg_total_out), .cfg_total_in(cfg_total_in),
        .cfg_img_size(cfg_img_size), .cfg_fil_size(cfg_fil_size),
        .cfg_pool_size(cfg_pool_size),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .img_we(img_we), .input_addr(input_addr), .write_img(write_img),
        .output_addr(output_addr),
        .net_we(net_we), .net_addr(net_addr), .write_net(write_net),
        .total_out(total_out), .total_in(total_in), .img_size(img_size),
        .fil_size(fil_size), .pool_size(pool_size),
        .req(req), .ack(ack),
`ifdef LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          net;
        logic [CL:0]   we;
        logic [IS-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] words[$];
    int            n_cmp = 0, n_fail = 0, n_req = 0, ref_cyc = 0;
    bit            mon_en = 1'b0, acc_prev = 1'b0;
    wr_t           mon_e;

    logic [159:0] all_outs;
    assign all_outs = {s_ready, img_we, input_addr, write_img, output_addr, net_we,
                       net_addr, write_net, total_out, total_in, img_size, fil_size,
                       pool_size, req, busy, done};

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Write-port monitor: every strobe must follow an acceptance and match the model list.
    always @(negedge clk) begin
        if (mon_en && xrst) begin
            check("strobe_after_accept", {159'b0, (img_we === 1'b1) || (net_we !== '0)}, {159'b0, acc_prev});
            if (img_we === 1'b1) begin
                if (exp_q.size() == 0) check("img_extra_write", exp_q.size(), 1);
                else begin
                    mon_e = exp_q.pop_front();
                    check("img_write", {1'b0, input_addr, write_img}, {mon_e.net, mon_e.addr, mon_e.data});
                end
            end
            if (net_we !== '0) begin
                if (exp_q.size() == 0) check("net_extra_write", exp_q.size(), 1);
                else begin
                    mon_e = exp_q.pop_front();
                    check("net_write", {1'b1, net_we, 1'b0, net_addr, write_net},
                          {mon_e.net, mon_e.we, mon_e.addr, mon_e.data});
                end
            end
            if (req === 1'b1) begin
                n_req++;
                check("req_latency", cyc - ref_cyc, 2);
            end
            if (start === 1'b1 && busy === 1'b0) ref_cyc = cyc;
            if (s_valid === 1'b1 && s_ready === 1'b1) ref_cyc = cyc;
        end
        acc_prev = xrst && (s_valid === 1'b1) && (s_ready === 1'b1);
    end

    task automatic fill_seq(input int n);
        words.delete();
        for (int k = 1; k <= n; k++) words.push_back(DW'(k));
    endtask

    task automatic fill_rand(input int n);
        words.delete();
        for (int k = 0; k < n; k++) words.push_back(DW'($urandom));
    endtask

    task automatic feed(input int n, input int stall, input int inj_s, input int inj_a);
        int i, budget, step;
        bit gap, ok;
        i = 0; budget = 0; step = 0;
        while (i < n && budget < 4000) begin
            gap = (stall == 1 && (step % 2) == 1) || (stall == 2 && $urandom_range(0, 2) == 0);
            step++; budget++;
            if (gap) begin
                s_valid = 1'b0;
                s_data  = DW'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = words[i];
                start   = (i == inj_s);
                ack     = (i == inj_a);
                if (start) img_words = IS'($urandom);
            end
            @(negedge clk);
            ok = (s_ready === 1'b1) && !gap;
            @(posedge clk); #1;
            start = 1'b0; ack = 1'b0; s_valid = 1'b0;
            if (ok) i++;
        end
        check("feed_complete", i, n);
    endtask

    task automatic run_job(input int img, input int net, input logic [IS-1:0] base,
                           input logic [IS-1:0] obase, input int stall,
                           input int inj_s, input int inj_a);
        logic [5*LW-1:0] cfg;
        logic [DW-1:0]   sum;
        bit              got;
        int              n;
        n = img + net * NC;
        exp_q.delete(); n_req = 0; sum = '0;
        for (int k = 0; k < img; k++) begin
            exp_q.push_back('{net: 1'b0, we: '0, addr: IS'(base + k), data: words[k]});
            sum = sum + words[k];
        end
        for (int c = 0; c < NC; c++)
            for (int j = 0; j < net; j++) begin
                exp_q.push_back('{net: 1'b1, we: (CL+1)'(c + 1), addr: IS'(j),
                                  data: words[img + c * net + j]});
                sum = sum + words[img + c * net + j];
            end
        @(posedge clk); #1;
        img_words = IS'(img); net_words = NS'(net); in_base = base; out_base = obase;
        cfg = {LW'($urandom), LW'($urandom), LW'($urandom), LW'($urandom), LW'($urandom)};
        {cfg_total_out, cfg_total_in, cfg_img_size, cfg_fil_size, cfg_pool_size} = cfg;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        img_words = IS'($urandom); net_words = NS'($urandom);
        in_base = IS'($urandom); out_base = IS'($urandom);
        {cfg_total_out, cfg_total_in, cfg_img_size, cfg_fil_size, cfg_pool_size} = 50'($urandom) ^ {cfg[49:32], 32'($urandom)};
        @(negedge clk);
        check("busy_after_start", busy, 1);
        check("ready_after_start", s_ready, (n > 0));
        check("layer_params", {total_out, total_in, img_size, fil_size, pool_size}, cfg);
`ifdef LOADER_CHECKSUM_EN
        check("checksum_cleared", checksum, 0);
`endif
        @(posedge clk); #1;
        feed(n, stall, inj_s, inj_a);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = (req === 1'b1);
        end
        check("req_seen", got, 1);
        @(posedge clk); #1;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        ack = 1'b1;
        @(negedge clk);
        check("done_not_early", done, 0);
        @(posedge clk); #1;
        ack = 1'b0;
        @(negedge clk);
        check("done_after_ack", {done, busy}, 2'b11);
        check("handshake_addrs", {input_addr, output_addr}, {base, obase});
        check("layer_params_held", {total_out, total_in, img_size, fil_size, pool_size}, cfg);
`ifdef LOADER_CHECKSUM_EN
        check("checksum_at_done", checksum, sum);
`endif
        @(negedge clk);
        check("idle_after_done", {busy, done}, 2'b00);
        check("all_writes_seen", exp_q.size(), 0);
        check("req_pulse_count", n_req, 1);
    endtask

    task automatic abort_job();
        mon_en = 1'b0;
        fill_rand(2 + 3 * NC);
        @(posedge clk); #1;
        img_words = IS'(2); net_words = NS'(3); in_base = IS'($urandom); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed(7, 0, -1, -1);
        @(negedge clk);
        check("abort_in_load_net", s_ready, 1);
        @(posedge clk); #2;
        s_valid = 1'b1; s_data = words[7];
        xrst = 1'b0;
        #1;
        check("abort_outputs_zero", all_outs, 0);
        @(posedge clk); @(posedge clk); #1;
        xrst = 1'b1;
        @(negedge clk);
        check("post_abort_outputs_zero", all_outs, 0);
`ifdef LOADER_CHECKSUM_EN
        check("post_abort_checksum", checksum, 0);
`endif
        @(posedge clk); #1;
        s_valid = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        xrst = 1'b0;
        repeat (3) @(posedge clk);
        #1 xrst = 1'b1;
        @(negedge clk);
        check("reset_outputs", all_outs, 0);
        @(negedge clk);
        check("reset_idle_hold", all_outs, 0);
`ifdef LOADER_CHECKSUM_EN
        check("reset_checksum", checksum, 0);
`endif
        mon_en = 1'b1;

        fill_seq(20);           run_job(4, 2, 12'h100, 12'h200, 0, -1, -1);
        fill_seq(20);           run_job(4, 2, 12'h100, 12'h200, 1, -1, -1);
        words.delete();         run_job(0, 0, IS'($urandom), IS'($urandom), 0, -1, -1);
        fill_rand(3 + NC);      run_job(3, 1, 12'hFFE, 12'h010, 0, -1, -1);
        fill_rand(4 + 2 * NC);  run_job(4, 2, IS'($urandom), IS'($urandom), 0, 6, 1);
        fill_rand(2 * NC);      run_job(0, 2, IS'($urandom), IS'($urandom), 2, -1, -1);
        for (int r = 0; r < 3; r++) begin
            int ri, rn;
            ri = $urandom_range(1, 10);
            rn = $urandom_range(1, 3);
            fill_rand(ri + rn * NC);
            run_job(ri, rn, IS'($urandom), IS'($urandom), 2, -1, -1);
        end
        abort_job();
        fill_rand(5 + NC);      run_job(5, 1, IS'($urandom), IS'($urandom), 1, -1, -1);

        words.delete(); words.push_back(16'h7FFF); words.push_back(16'h0001);
        run_job(2, 0, IS'($urandom), IS'($urandom), 0, -1, -1);
        fill_rand(3);           run_job(3, 0, IS'($urandom), IS'($urandom), 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
